rate_timestamper: RTL
=====================

RATE_TIMESTAMPER -- requirements
Module: rate_timestamper

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CNT_W, 16, width of the per-second hit counter and of secRate.
- MIN_W, 24, width of the per-minute hit accumulator and of minRate.
- STAMP_W, 16, width of the seconds-since-reset timestamp.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK, in, 1, 9.6 MHz system clock; the only clock.
- RST, in, 1, reset; synchronous and active-high.
- hit, in, 1, discriminator output, asynchronous to CLK, active-high.
- sec, in, 1, seconds toggle from the time base; changes level once per second, CLK-synchronous.
- min, in, 1, minutes toggle from the time base; changes level once per minute, CLK-synchronous.
- outData, out, STAMP_W+CNT_W, record {secStamp, secRate}.
- outValid, out, 1, record available.
- outReady, in, 1, consumer accepts the record.
- minRate, out, MIN_W, hit count of the last completed minute.
- minStrobe, out, 1, one-cycle pulse when minRate updates.
- overrun, out, 1, sticky flag: a record was dropped.
- clrOvr, in, 1, clears overrun.

Function
REQ-003 hit SHALL pass through a 2-FF synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle hitEdge.
REQ-004 hit SHALL be high for at least 2 CLK periods to be counted; a rising edge at hit SHALL be counted by the 3rd CLK edge.
REQ-005 sec and min SHALL each be registered once; any level change between the registered value and its previous value SHALL produce a one-cycle tick (secTick or minTick).
REQ-006 The second counter SHALL increment on each hitEdge and SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-007 On secTick, secRate SHALL latch the second counter's value excluding any same-cycle hitEdge; the counter SHALL restart at 1 if hitEdge is present in that cycle, else 0.
REQ-008 On secTick, secStamp SHALL increment modulo 2^STAMP_W; the first record after reset SHALL carry secStamp=1.
REQ-009 The minute accumulator SHALL follow the same rules as REQ-006 and REQ-007 at MIN_W width, driven by minTick.
REQ-010 On minTick, minRate SHALL latch the accumulator and minStrobe SHALL pulse for exactly 1 cycle, 1 edge after the tick cycle.
REQ-011 A secTick and a minTick in the same cycle SHALL be handled independently; neither SHALL delay the other.
REQ-012 The output buffer SHALL be a one-entry FSM with states EMPTY and FULL, and outValid SHALL be 1 exactly in FULL.
REQ-013 In EMPTY, a secTick SHALL load outData and move to FULL on the next edge.
- outValid therefore rises 2 CLK edges after sec changes.
REQ-014 In FULL, outValid=1 with outReady=1 at an edge SHALL complete a transfer and return to EMPTY.
- If a secTick coincides with that transfer, the new record SHALL load instead and the state SHALL stay FULL, with no gap and no drop.
REQ-015 In FULL with outReady=0, a secTick SHALL leave outData unchanged, drop the new record and set overrun.
- The internal counters and secStamp SHALL still advance.
REQ-016 outData SHALL stay stable while outValid=1 and outReady=0.
REQ-017 overrun SHALL stay set until clrOvr=1 at an edge.
- If clrOvr and a drop occur in the same cycle, overrun SHALL remain set.

Reset
REQ-018 When RST=1 at an edge, the block SHALL clear the synchronizer flops, both counters, secStamp, secRate, minRate, outData, minStrobe, overrun and outValid to 0, and set the FSM to EMPTY.
REQ-019 When RST=1 at an edge, the registered sec and min SHALL load the current input levels so no spurious tick follows reset.
REQ-020 RST SHALL take priority over all other inputs, including mid-transfer.
- A record pending at reset SHALL be discarded.

Verification
REQ-021 Apply 5 hits of 4 cycles each, then toggle sec, with outReady=1 -> outData=0x0001_0005, outValid high 1 cycle, 2 edges after the toggle.
REQ-022 Hold outReady=0 across 3 sec toggles -> first record held unchanged, overrun=1; after outReady=1, next record carries secStamp=4.
REQ-023 Rising hit edge synchronized in the same cycle as secTick -> record excludes it, next record counts it (secRate=1 with no further hits).
REQ-024 Apply 70000 hits in one second -> secRate=0xFFFF; then toggle min -> minRate=70000, minStrobe pulses 1 cycle.
REQ-025 Assert RST while outValid=1 and the counters are nonzero -> all outputs 0 next cycle; 1 sec toggle later, secStamp=1 and secRate counts only post-reset hits.
REQ-026 Apply clrOvr in the same cycle as a drop -> overrun stays 1; apply clrOvr alone -> overrun=0.

Source files
------------

// File: rtl/rate_timestamper.sv
// Rate timestamper: counts synchronized hit edges per second and per minute,
// and emits one {secStamp, secRate} record per second through a one-entry
// valid/ready buffer. Records that arrive while the buffer is still held are
// dropped and flagged in a sticky overrun bit.
module rate_timestamper #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_W   = 24,
  parameter int unsigned STAMP_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     hit,
  input  logic                     sec,
  input  logic                     min,
  output logic [STAMP_W+CNT_W-1:0] outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [MIN_W-1:0]         minRate,
  output logic                     minStrobe,
  output logic                     overrun,
  input  logic                     clrOvr
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [MIN_W-1:0] MinMax = '1;

  typedef enum logic {StEmpty, StFull} state_e;

  // Synchronizer and edge/tick detection state
  logic hit_meta_q, hit_sync_q, hit_prev_q;
  logic sec_q, sec_prev_q;
  logic min_q, min_prev_q;

  logic hit_edge;
  logic sec_tick;
  logic min_tick;

  // Counters and timestamp
  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [MIN_W-1:0]   min_acc_q, min_acc_d;
  logic [STAMP_W-1:0] sec_stamp_q, sec_stamp_d;

  // Output side
  state_e                   state_q, state_d;
  logic                     load;
  logic                     drop;
  logic [STAMP_W+CNT_W-1:0] out_data_q;
  logic [MIN_W-1:0]         min_rate_q;
  logic                     min_strobe_q;
  logic                     overrun_q;

  assign hit_edge = hit_sync_q & ~hit_prev_q;
  assign sec_tick = sec_q ^ sec_prev_q;
  assign min_tick = min_q ^ min_prev_q;

  // Two-flop hit synchronizer plus edge history; sec/min registered once plus history.
  // On reset the sec/min history loads the live levels so no tick follows reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_meta_q <= 1'b0;
      hit_sync_q <= 1'b0;
      hit_prev_q <= 1'b0;
      sec_q      <= sec;
      sec_prev_q <= sec;
      min_q      <= min;
      min_prev_q <= min;
    end else begin
      hit_meta_q <= hit;
      hit_sync_q <= hit_meta_q;
      hit_prev_q <= hit_sync_q;
      sec_q      <= sec;
      sec_prev_q <= sec_q;
      min_q      <= min;
      min_prev_q <= min_q;
    end
  end

  // Per-second counter: saturating; on a tick it restarts, keeping a same-cycle edge.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (sec_tick) begin
      sec_cnt_d = hit_edge ? CNT_W'(1) : '0;
    end else if (hit_edge && (sec_cnt_q != CntMax)) begin
      sec_cnt_d = sec_cnt_q + CNT_W'(1);
    end
  end

  // Per-minute accumulator: same rules as the second counter, driven by min ticks.
  always_comb begin
    min_acc_d = min_acc_q;
    if (min_tick) begin
      min_acc_d = hit_edge ? MIN_W'(1) : '0;
    end else if (hit_edge && (min_acc_q != MinMax)) begin
      min_acc_d = min_acc_q + MIN_W'(1);
    end
  end

  // Seconds-since-reset stamp, wraps naturally.
  always_comb begin
    sec_stamp_d = sec_stamp_q;
    if (sec_tick) begin
      sec_stamp_d = sec_stamp_q + STAMP_W'(1);
    end
  end

  // Counter, stamp and minute-rate registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_cnt_q    <= '0;
      min_acc_q    <= '0;
      sec_stamp_q  <= '0;
      min_rate_q   <= '0;
      min_strobe_q <= 1'b0;
    end else begin
      sec_cnt_q    <= sec_cnt_d;
      min_acc_q    <= min_acc_d;
      sec_stamp_q  <= sec_stamp_d;
      min_strobe_q <= min_tick;
      if (min_tick) begin
        min_rate_q <= min_acc_q;
      end
    end
  end

  // One-entry buffer: next state plus load/drop decisions for a new record.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (sec_tick) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (outReady) begin
          // A transfer completes; a coinciding record refills without a gap.
          if (sec_tick) begin
            load = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end else if (sec_tick) begin
          drop = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Buffer state, held record and sticky overrun; a drop beats a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // The secRate field is the counter value before this cycle's edge.
        out_data_q <= {sec_stamp_d, sec_cnt_q};
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clrOvr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign outData   = out_data_q;
  assign outValid  = (state_q == StFull);
  assign minRate   = min_rate_q;
  assign minStrobe = min_strobe_q;
  assign overrun   = overrun_q;

endmodule
